lfsr_seq: RTL

Parametrised Fibonacci LFSR pattern generator for board LED/segment demos and test-pattern sources.
- Generalises the fixed 8-bit LED shifter: configurable width and taps, optional de Bruijn (all-zero-inclusive) sequence, forward/reverse stepping, seed load, single-step, and period-wrap detection.
- Advances on an internal clock-enable prescaler, never a derived clock.
- Sits between the board buttons/switches and the LED / hex-digit display path.

---
 rtl/lfsr_pkg.sv | 49 ++++
 rtl/lfsr_seq_tick_gen.sv | 37 +++
 rtl/lfsr_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR step functions and default feedback masks.
// Functions work on a 32-bit container; the active width is passed in so
// one definition serves every WIDTH from 3 to 32.
package lfsr_pkg;

   // Feedback masks (polynomial without the x^W term), primitive in the
   // right-shifting Fibonacci form used by lfsr_fwd.
   localparam logic [31:0] TAPS_W8  = 32'h0000_001D;
   localparam logic [31:0] TAPS_W16 = 32'h0000_100B;
   localparam logic [31:0] TAPS_W32 = 32'h0040_0007;

   function automatic logic [31:0] lfsr_mask(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
   endfunction

   // One forward step: feedback enters at the MSB, state shifts right.
   // The de Bruijn term flips feedback when bits [w-1:1] are all zero,
   // splicing the all-zero state into the cycle between 1 and 2^(w-1).
   function automatic logic [31:0] lfsr_fwd(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input logic        debruijn,
                                            input int unsigned w);
      logic [31:0] s;
      logic [31:0] upper;
      logic        fb;
      s     = state & lfsr_mask(w);
      upper = s >> 1;
      fb    = (^(s & taps)) ^ (debruijn & ~(|upper));
      return upper | ({31'd0, fb} << (w - 1));
   endfunction

   // Exact inverse of lfsr_fwd: recovers the bit that fell off the LSB.
   // Relies on taps[0] being set so the old bit 0 is the only unknown.
   function automatic logic [31:0] lfsr_rev(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input logic        debruijn,
                                            input int unsigned w);
      logic [31:0] s;
      logic [31:0] low;
      logic        msb;
      logic        b0;
      s   = state & lfsr_mask(w);
      low = s & (lfsr_mask(w) >> 1);
      msb = |(s & (32'h1 << (w - 1)));
      b0  = msb ^ (^(low & (taps >> 1))) ^ (debruijn & ~(|low));
      return (low << 1) | {31'd0, b0};
   endfunction

endpackage

// File: rtl/lfsr_seq_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every DIV cycles while en is high.
// The count is held at zero while en is low, so each run of en starts a
// fresh period and the first tick lands DIV cycles after en rises.
module tick_gen #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Tick on the last count of a period; wrap or hold at zero otherwise.
   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = '0;
      if (en && !tick) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lfsr_seq.sv
// Fibonacci LFSR pattern generator with forward/reverse stepping,
// seed/clear/set overrides and period-wrap detection against a reference
// value captured on reset or on any explicit state write.
module lfsr_seq
   import lfsr_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter logic [31:0] TAPS      = TAPS_W8,
   parameter bit          DEBRUIJN  = 1'b1,
   parameter logic [31:0] RESET_VAL = 32'h1,
   parameter int unsigned DIV       = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             step,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             clr,
   input  logic             set,
   output logic [WIDTH-1:0] state,
   output logic             stepped,
   output logic             wrap,
   output logic [WIDTH:0]   step_cnt,
   output logic             locked
);

   logic             tick;
   logic             adv;
   logic [WIDTH-1:0] fwd_nx;
   logic [WIDTH-1:0] rev_nx;
   logic [WIDTH-1:0] step_nx;

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic             stepped_q, stepped_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH:0]   cnt_q, cnt_d;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   assign fwd_nx = WIDTH'(lfsr_fwd(32'(state_q), TAPS, DEBRUIJN, WIDTH));
   assign rev_nx = WIDTH'(lfsr_rev(32'(state_q), TAPS, DEBRUIJN, WIDTH));

   // Next-state: explicit writes capture a new reference; an advance moves
   // once (step and tick together still give a single move).
   always_comb begin
      adv       = step | (en & tick);
      step_nx   = dir ? rev_nx : fwd_nx;
      state_d   = state_q;
      ref_d     = ref_q;
      stepped_d = 1'b0;
      wrap_d    = 1'b0;
      cnt_d     = cnt_q;
      if (clr) begin
         state_d = '0;
         ref_d   = '0;
         cnt_d   = '0;
      end else if (set) begin
         state_d = '1;
         ref_d   = '1;
         cnt_d   = '0;
      end else if (load) begin
         state_d = seed;
         ref_d   = seed;
         cnt_d   = '0;
      end else if (adv) begin
         state_d   = step_nx;
         stepped_d = 1'b1;
         if (step_nx == ref_q) begin
            wrap_d = 1'b1;
            cnt_d  = '0;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset overrides every other request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RESET_VAL[WIDTH-1:0];
         ref_q     <= RESET_VAL[WIDTH-1:0];
         stepped_q <= 1'b0;
         wrap_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ref_q     <= ref_d;
         stepped_q <= stepped_d;
         wrap_q    <= wrap_d;
         cnt_q     <= cnt_d;
      end
   end

   assign state    = state_q;
   assign stepped  = stepped_q;
   assign wrap     = wrap_q;
   assign step_cnt = cnt_q;
   assign locked   = (state_q == '0) && !DEBRUIJN;

endmodule
